// File: rtl/lsu_pkg.sv
// ============================================================================
// lsu_pkg : opcode, access-size and memory-size constants for the LSU
// Rev 1.0
// ============================================================================
`default_nettype none

package lsu_pkg;

   localparam logic [5:0] OP_LB  = 6'h20;
   localparam logic [5:0] OP_LH  = 6'h21;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_LBU = 6'h24;
   localparam logic [5:0] OP_LHU = 6'h25;
   localparam logic [5:0] OP_SB  = 6'h28;
   localparam logic [5:0] OP_SH  = 6'h29;
   localparam logic [5:0] OP_SW  = 6'h2B;

   localparam logic [2:0] SZ_NONE = 3'd0;
   localparam logic [2:0] SZ_B    = 3'd1;
   localparam logic [2:0] SZ_H    = 3'd2;
   localparam logic [2:0] SZ_W    = 3'd4;

   localparam int unsigned MEM_SIZE = 1024;

endpackage

`default_nettype wire

// File: rtl/lsu_decode.sv
// ============================================================================
// lsu_decode : MIPS load/store opcode -> access class, size and sign
// Rev 1.0
// ============================================================================
`default_nettype none

module lsu_decode
   import lsu_pkg::*;
(
   input  logic [5:0] i_op,
   output logic       o_is_load,
   output logic       o_is_store,
   output logic [2:0] o_size,
   output logic       o_sign,
   output logic       o_bad_op
);

   always_comb begin
      o_is_load  = 1'b0;
      o_is_store = 1'b0;
      o_size     = SZ_NONE;
      o_sign     = 1'b0;
      o_bad_op   = 1'b0;
      case (i_op)
         OP_LB:  begin o_is_load  = 1'b1; o_size = SZ_B; o_sign = 1'b1; end
         OP_LH:  begin o_is_load  = 1'b1; o_size = SZ_H; o_sign = 1'b1; end
         OP_LW:  begin o_is_load  = 1'b1; o_size = SZ_W; o_sign = 1'b1; end
         OP_LBU: begin o_is_load  = 1'b1; o_size = SZ_B; end
         OP_LHU: begin o_is_load  = 1'b1; o_size = SZ_H; end
         OP_SB:  begin o_is_store = 1'b1; o_size = SZ_B; end
         OP_SH:  begin o_is_store = 1'b1; o_size = SZ_H; end
         OP_SW:  begin o_is_store = 1'b1; o_size = SZ_W; end
         default: o_bad_op = 1'b1;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/lsu.sv
// ============================================================================
// lsu : single-request load/store unit driving a big-endian byte RAM port
// Rev 1.0
// ============================================================================
`default_nettype none

module lsu
   import lsu_pkg::*;
#(
   parameter int unsigned MEM_BYTES = MEM_SIZE
)
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_req,
   input  logic [5:0]  i_op,
   input  logic [31:0] i_base,
   input  logic [15:0] i_offset,
   input  logic [31:0] i_wdata,
   output logic        o_busy,
   output logic        o_done,
   output logic [31:0] o_rdata,
   output logic        o_addr_err,
   output logic        o_err_store,
   output logic        o_bad_op,
   output logic [31:0] o_mem_addr,
   output logic [2:0]  o_mem_insize,
   output logic        o_mem_insign,
   output logic [2:0]  o_mem_outsize,
   output logic [31:0] o_mem_data,
   input  logic [31:0] i_mem_data
);

   localparam logic [1:0]  S_IDLE   = 2'd0;
   localparam logic [1:0]  S_ACCESS = 2'd1;
   localparam logic [1:0]  S_RESP   = 2'd2;
   localparam logic [32:0] c_mem_lim = 33'(MEM_BYTES);

   logic [1:0]  r_state;
   logic        r_is_load;
   logic        r_is_store;
   logic [2:0]  r_size;
   logic        r_sign;
   logic [31:0] r_rdata;
   logic        r_addr_err;
   logic        r_err_store;
   logic        r_bad_op;
   logic [31:0] r_mem_addr;
   logic [31:0] r_mem_data;

   logic        w_is_load;
   logic        w_is_store;
   logic [2:0]  w_size;
   logic        w_sign;
   logic        w_bad_op;
   logic [31:0] w_ea;
   logic [32:0] w_end;
   logic        w_misalign;
   logic        w_range;
   logic        w_access;

   lsu_decode u_decode (
      .i_op       (i_op),
      .o_is_load  (w_is_load),
      .o_is_store (w_is_store),
      .o_size     (w_size),
      .o_sign     (w_sign),
      .o_bad_op   (w_bad_op)
   );

   assign w_ea       = i_base + {{16{i_offset[15]}}, i_offset};
   // Extended to 33 bits so an access running past 2^32 cannot wrap into range.
   assign w_end      = {1'b0, w_ea} + {30'd0, w_size};
   assign w_misalign = ((w_size == SZ_H) && w_ea[0]) ||
                       ((w_size == SZ_W) && (w_ea[1:0] != 2'b00));
   assign w_range    = (w_end > c_mem_lim);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_is_load   <= 1'b0;
         r_is_store  <= 1'b0;
         r_size      <= SZ_NONE;
         r_sign      <= 1'b0;
         r_rdata     <= 32'd0;
         r_addr_err  <= 1'b0;
         r_err_store <= 1'b0;
         r_bad_op    <= 1'b0;
         r_mem_addr  <= 32'd0;
         r_mem_data  <= 32'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_req) begin
                  r_is_load  <= w_is_load;
                  r_is_store <= w_is_store;
                  r_size     <= w_size;
                  r_sign     <= w_sign;
                  if (w_bad_op) begin
                     r_bad_op <= 1'b1;
                     r_state  <= S_RESP;
                  end else if (w_misalign || w_range) begin
                     r_addr_err  <= 1'b1;
                     r_err_store <= w_is_store;
                     r_state     <= S_RESP;
                  end else begin
                     r_mem_addr <= w_ea;
                     if (w_is_store) begin
                        r_mem_data <= i_wdata;
                     end
                     r_state <= S_ACCESS;
                  end
               end
            end
            S_ACCESS: begin
               if (r_is_load) begin
                  r_rdata <= i_mem_data;
               end
               r_state <= S_RESP;
            end
            S_RESP: begin
               r_addr_err  <= 1'b0;
               r_err_store <= 1'b0;
               r_bad_op    <= 1'b0;
               r_state     <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Strobes decode from state so an async reset kills a pending write at once.
   assign w_access      = (r_state == S_ACCESS);
   assign o_mem_insize  = (w_access && r_is_load)  ? r_size : SZ_NONE;
   assign o_mem_insign  = w_access && r_is_load && r_sign;
   assign o_mem_outsize = (w_access && r_is_store) ? r_size : SZ_NONE;
   assign o_mem_addr    = r_mem_addr;
   assign o_mem_data    = r_mem_data;

   assign o_busy      = (r_state != S_IDLE);
   assign o_done      = (r_state == S_RESP);
   assign o_rdata     = r_rdata;
   assign o_addr_err  = r_addr_err;
   assign o_err_store = r_err_store;
   assign o_bad_op    = r_bad_op;

endmodule

`default_nettype wire
